// File: rtl/dff_pipe_if.sv
// Bus bundle for dff_pipe: stall/flush controls, input sample with its qualifier,
// and the delayed sample, its qualifier and the occupancy count.
interface dff_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             en;
  logic             flush;
  logic [WIDTH-1:0] D;
  logic             in_valid;
  logic [WIDTH-1:0] Q;
  logic             out_valid;
  logic [CW-1:0]    count;

  modport master (
    output en, flush, D, in_valid,
    input  Q, out_valid, count
  );

  modport slave (
    input  en, flush, D, in_valid,
    output Q, out_valid, count
  );
endinterface

// File: rtl/dff_pipe.sv
// Multi-stage WIDTH-bit delay line with per-stage valid bits, stall, flush
// and a running count of how many stages hold valid data.
module dff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic        clk,
  input logic        rst,
  dff_pipe_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [CW-1:0]    count_q;

  // Flush clears only the qualifiers; stale data stays behind on purpose.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= RESET_VAL;
      end
      vld     <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      vld     <= '0;
      count_q <= '0;
    end else if (bus.en) begin
      data[0] <= bus.D;
      vld[0]  <= bus.in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data[i] <= data[i-1];
        vld[i]  <= vld[i-1];
      end
      count_q <= count_q + CW'(bus.in_valid) - CW'(vld[DEPTH-1]);
    end
  end

  assign bus.Q         = data[DEPTH-1];
  assign bus.out_valid = vld[DEPTH-1];
  assign bus.count     = count_q;
endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: directed scenarios plus random traffic,
// all compared against a queue-based model of the delay line.
module tb_dff_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] RVAL = 8'h00;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [WIDTH-1:0] mdata [$];
  bit               mvld  [$];

  dff_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RVAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int model_count();
    int c = 0;
    foreach (mvld[i]) if (mvld[i]) c++;
    return c;
  endfunction

  task automatic checkOutput(input string tag);
    logic [WIDTH-1:0] exp_q;
    logic             exp_v;
    logic [CW-1:0]    exp_c;
    exp_q = mdata[DEPTH-1];
    exp_v = mvld[DEPTH-1];
    exp_c = CW'(model_count());
    checks++;
    assert (bus.Q === exp_q) else begin
      errors++;
      $error("[TB] FAIL %s.Q observed=%h expected=%h", tag, bus.Q, exp_q);
    end
    checks++;
    assert (bus.out_valid === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s.out_valid observed=%b expected=%b", tag, bus.out_valid, exp_v);
    end
    checks++;
    assert (bus.count === exp_c) else begin
      errors++;
      $error("[TB] FAIL %s.count observed=%0d expected=%0d", tag, bus.count, exp_c);
    end
  endtask

  task automatic checkValue(input string tag, input logic [WIDTH-1:0] q, input logic v,
                            input int c, input bit check_q);
    if (check_q) begin
      checks++;
      assert (bus.Q === q) else begin
        errors++;
        $error("[TB] FAIL %s.Q observed=%h expected=%h", tag, bus.Q, q);
      end
    end
    checks++;
    assert (bus.out_valid === v && bus.count === CW'(c)) else begin
      errors++;
      $error("[TB] FAIL %s observed v=%b c=%0d expected v=%b c=%0d",
             tag, bus.out_valid, bus.count, v, c);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic f,
                               input logic [WIDTH-1:0] d, input logic iv,
                               input string tag);
    @(negedge clk);
    rst          = r;
    bus.en       = e;
    bus.flush    = f;
    bus.D        = d;
    bus.in_valid = iv;
    @(posedge clk);
    if (r) begin
      foreach (mdata[i]) begin
        mdata[i] = RVAL;
        mvld[i]  = 1'b0;
      end
    end else if (f) begin
      foreach (mvld[i]) mvld[i] = 1'b0;
    end else if (e) begin
      mdata.push_front(d);
      mvld.push_front(iv);
      void'(mdata.pop_back());
      void'(mvld.pop_back());
    end
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.flush = 1'b0; bus.D = '0; bus.in_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mdata.push_back('0);
      mvld.push_back(1'b0);
    end

    // Reset held with live inputs
    applyStimulus(1, 1, 0, 8'hFF, 1, "rst0");
    checkValue("rst0_const", 8'h00, 0, 0, 1);
    applyStimulus(1, 1, 0, 8'hFF, 1, "rst1");
    checkValue("rst1_const", 8'h00, 0, 0, 1);
    applyStimulus(0, 0, 0, 8'hFF, 1, "rst_rel");
    checkValue("rst_rel_const", 8'h00, 0, 0, 1);

    // Latency: one valid sample
    applyStimulus(0, 1, 0, 8'hA5, 1, "lat0");
    for (int i = 1; i < DEPTH; i++) applyStimulus(0, 1, 0, 8'h00, 0, "lat");
    checkValue("lat_emerge", 8'hA5, 1, 1, 1);
    applyStimulus(0, 1, 0, 8'h00, 0, "lat_gone");
    checkValue("lat_gone_const", 8'h00, 0, 0, 0);

    // Stall in the middle of a stream
    applyStimulus(0, 1, 0, 8'h01, 1, "st1");
    applyStimulus(0, 1, 0, 8'h02, 1, "st2");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 8'hEE, 1, "stall");
      checkValue("stall_hold", 8'h00, 0, 2, 0);
    end
    applyStimulus(0, 1, 0, 8'h03, 1, "st3");
    applyStimulus(0, 1, 0, 8'h04, 1, "st4");
    checkValue("st_out1", 8'h01, 1, 4, 1);
    applyStimulus(0, 1, 0, 8'h00, 0, "st5");
    checkValue("st_out2", 8'h02, 1, 3, 1);
    applyStimulus(0, 1, 0, 8'h00, 0, "st6");
    checkValue("st_out3", 8'h03, 1, 2, 1);
    applyStimulus(0, 1, 0, 8'h00, 0, "st7");
    checkValue("st_out4", 8'h04, 1, 1, 1);
    applyStimulus(0, 1, 0, 8'h00, 0, "st8");

    // Count ramps up, saturates at DEPTH, then drains
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(0, 1, 0, WIDTH'(8'h10 + k), 1, "fill");
      checkValue("fill_cnt", 8'h00, k >= DEPTH, (k < DEPTH) ? k : DEPTH, 0);
    end
    for (int k = DEPTH - 1; k >= 0; k--) begin
      applyStimulus(0, 1, 0, 8'h00, 0, "drain");
      checkValue("drain_cnt", 8'h00, k > 0, k, 0);
    end

    // Flush beats en/in_valid on the same edge
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, WIDTH'(8'h20 + k), 1, "pre_fl");
    applyStimulus(0, 1, 1, 8'h77, 1, "flush");
    checkValue("flush_const", 8'h00, 0, 0, 0);
    for (int k = 0; k < DEPTH + 1; k++) begin
      applyStimulus(0, 1, 0, 8'h00, 0, "post_fl");
      checkValue("post_fl_const", 8'h00, 0, 0, 0);
    end

    // Reset while full
    for (int k = 0; k < DEPTH; k++) applyStimulus(0, 1, 0, WIDTH'(8'h30 + k), 1, "pre_rst");
    applyStimulus(1, 1, 0, 8'h99, 1, "mid_rst");
    checkValue("mid_rst_const", RVAL, 0, 0, 1);
    applyStimulus(0, 1, 0, 8'h3C, 1, "new0");
    for (int i = 1; i < DEPTH; i++) applyStimulus(0, 1, 0, 8'h00, 0, "new");
    checkValue("new_emerge", 8'h3C, 1, 1, 1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 19) == 0), WIDTH'($urandom), $urandom_range(0, 1),
                    "rand");
      checks++;
      assert (!(bus.count === '0 && bus.out_valid === 1'b1)) else begin
        errors++;
        $error("[TB] FAIL rand_consist observed count=%0d out_valid=%b expected out_valid=0",
               bus.count, bus.out_valid);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
